// File: rtl/step_move_ctrl.sv
// step_move_ctrl: drives a signed up/down step counter toward a latched target.
// A move command (target + step period) becomes single-cycle step pulses and a
// direction level. The counter's live count comes back as position_i, and the
// move ends when position_i equals the target. After any direction change, dir_o
// is held stable for DIR_SETUP_CYCLES before the next step.
//
// Ports:
//   clk_i          system clock
//   rst_ni         synchronous active-low reset
//   go_i           start-move strobe, honoured only when idle
//   stop_i         abort; overrides go_i and any pending step
//   target_i       signed destination, latched on an accepted go
//   step_period_i  cycles between step rising edges, latched on an accepted go
//   position_i     signed live count from the step counter
//   step_o         one-cycle step pulse (counter enable)
//   dir_o          1 = count up, 0 = count down
//   busy_o         move in progress
//   done_o         one-cycle pulse on normal completion
module step_move_ctrl #(
  parameter int unsigned POS_W            = 10,
  parameter int unsigned PERIOD_W         = 16,
  parameter int unsigned DIR_SETUP_CYCLES = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                go_i,
  input  logic                stop_i,
  input  logic [POS_W-1:0]    target_i,
  input  logic [PERIOD_W-1:0] step_period_i,
  input  logic [POS_W-1:0]    position_i,
  output logic                step_o,
  output logic                dir_o,
  output logic                busy_o,
  output logic                done_o
);

  typedef enum logic [1:0] {StIdle, StSetup, StRun} state_e;

  localparam logic [PERIOD_W-1:0] SetupLoad = PERIOD_W'(DIR_SETUP_CYCLES - 1);
  localparam logic [PERIOD_W-1:0] MinPer    = PERIOD_W'(2);
  localparam logic [PERIOD_W-1:0] One       = PERIOD_W'(1);

  state_e              state_q, state_d;
  logic                step_q, step_d;
  logic                dir_q, dir_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [PERIOD_W-1:0] timer_q, timer_d;
  logic [PERIOD_W-1:0] per_q, per_d;
  logic [POS_W-1:0]    target_q, target_d;

  logic [POS_W-1:0]    tgt_sel;
  logic [POS_W:0]      diff;
  logic                at_target;
  logic                want_up;
  logic [PERIOD_W-1:0] per_clamped;

  // In idle the decision uses the target being latched this cycle.
  assign tgt_sel = (state_q == StIdle) ? target_i : target_q;

  // One extra bit keeps the full -1023..+1023 range without overflow.
  assign diff      = {tgt_sel[POS_W-1], tgt_sel} - {position_i[POS_W-1], position_i};
  assign at_target = (diff == '0);
  assign want_up   = ~diff[POS_W] & ~at_target;

  // A period of at least 2 lets position_i reflect the last step before the
  // next slot is evaluated.
  assign per_clamped = (step_period_i < MinPer) ? MinPer : step_period_i;

  always_comb begin
    state_d  = state_q;
    step_d   = 1'b0;
    done_d   = 1'b0;
    dir_d    = dir_q;
    busy_d   = busy_q;
    timer_d  = timer_q;
    target_d = target_q;
    per_d    = per_q;

    if (stop_i) begin
      state_d = StIdle;
      busy_d  = 1'b0;
      timer_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          busy_d = 1'b0;
          if (go_i) begin
            target_d = target_i;
            per_d    = per_clamped;
            if (at_target) begin
              done_d = 1'b1;
            end else if (want_up == dir_q) begin
              state_d = StRun;
              busy_d  = 1'b1;
              step_d  = 1'b1;
              timer_d = per_clamped - One;
            end else begin
              state_d = StSetup;
              busy_d  = 1'b1;
              dir_d   = ~dir_q;
              timer_d = SetupLoad;
            end
          end
        end

        StSetup: begin
          if (timer_q == '0) begin
            state_d = StRun;
            step_d  = 1'b1;
            timer_d = per_q - One;
          end else begin
            timer_d = timer_q - One;
          end
        end

        StRun: begin
          if (timer_q != '0) begin
            timer_d = timer_q - One;
          end else if (at_target) begin
            state_d = StIdle;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            timer_d = '0;
          end else if (want_up == dir_q) begin
            step_d  = 1'b1;
            timer_d = per_q - One;
          end else begin
            // Position moved past or away from target: turn around first.
            state_d = StSetup;
            dir_d   = ~dir_q;
            timer_d = SetupLoad;
          end
        end

        default: begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      step_q   <= 1'b0;
      dir_q    <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      timer_q  <= '0;
      per_q    <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      dir_q    <= dir_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      timer_q  <= timer_d;
      per_q    <= per_d;
      target_q <= target_d;
    end
  end

  assign step_o = step_q;
  assign dir_o  = dir_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_step_move_ctrl.sv
// Bench for step_move_ctrl. A loadable step counter closes the loop on
// position. The reference is a schedule model: from each accepted move it works
// out when steps, busy, done and the dir flip must occur, using plain
// arithmetic on the distance, period and setup time.
module tb_step_move_ctrl;

  localparam int PW = 10;
  localparam int QW = 16;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          go;
  logic          stop;
  logic [PW-1:0] target;
  logic [QW-1:0] sp;
  logic [PW-1:0] pos;
  logic          step;
  logic          dir;
  logic          busy;
  logic          done;

  logic          load_en;
  logic [PW-1:0] load_val;

  always #5 clk = ~clk;

  step_move_ctrl #(
    .POS_W           (PW),
    .PERIOD_W        (QW),
    .DIR_SETUP_CYCLES(D)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .go_i         (go),
    .stop_i       (stop),
    .target_i     (target),
    .step_period_i(sp),
    .position_i   (pos),
    .step_o       (step),
    .dir_o        (dir),
    .busy_o       (busy),
    .done_o       (done)
  );

  // Step counter driven by the DUT (wraps naturally at 10 bits).
  always @(posedge clk) begin
    if (load_en) pos <= load_val;
    else if (step) pos <= dir ? pos + 10'd1 : pos - 10'd1;
  end

  int   cyc;
  int   n_cmp;
  int   n_err;
  logic chk_en;

  // Model of the current/last move.
  logic m_valid, m_dir0, m_rst;
  int   m_go_cyc, m_p0, m_t, m_per, m_end, m_rst_c;

  // Observations of the current move.
  int obs_steps[$];
  int obs_done, obs_dir0_cnt, obs_dir_c1, obs_busy_cnt;

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int mv_n();
    return m_valid ? iabs(m_t - m_p0) : 0;
  endfunction

  function automatic logic mv_toggle();
    logic up;
    up = (m_t > m_p0);
    return (mv_n() != 0) && (up != m_dir0);
  endfunction

  function automatic int mv_first();
    return mv_toggle() ? 1 + D : 1;
  endfunction

  function automatic int mv_done_c();
    return (mv_n() == 0) ? 1 : mv_first() + mv_n() * m_per;
  endfunction

  function automatic logic e_step(int c);
    int f;
    if (!m_valid || c > m_end || mv_n() == 0) return 1'b0;
    f = mv_first();
    return (c >= f) && (((c - f) % m_per) == 0) && (((c - f) / m_per) < mv_n());
  endfunction

  function automatic logic e_done(int c);
    return m_valid && (c <= m_end) && (c == mv_done_c());
  endfunction

  function automatic logic e_busy(int c);
    return m_valid && (c <= m_end) && (mv_n() > 0) && (c >= 1) && (c < mv_done_c());
  endfunction

  function automatic logic e_dir(int c);
    int cc;
    if (m_rst && c > m_rst_c) return 1'b1;
    if (!m_valid) return m_dir0;
    cc = (c < m_end) ? c : m_end;
    return (mv_toggle() && cc >= 1) ? ~m_dir0 : m_dir0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_cycle();
    int c;
    c = cyc - m_go_cyc;
    chk("step", int'(step), int'(e_step(c)));
    chk("dir",  int'(dir),  int'(e_dir(c)));
    chk("busy", int'(busy), int'(e_busy(c)));
    chk("done", int'(done), int'(e_done(c)));
    if (step) obs_steps.push_back(c);
    if (done && obs_done < 0) obs_done = c;
    if (!dir) obs_dir0_cnt++;
    if (busy) obs_busy_cnt++;
    if (c == 1) obs_dir_c1 = int'(dir);
  endtask

  // Sample mid-cycle, then move to the drive point 2 time units after the edge.
  task automatic tick();
    @(negedge clk);
    if (chk_en) check_cycle();
    @(posedge clk);
    cyc++;
    #2;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic load(input int v);
    load_en  = 1'b1;
    load_val = PW'(v);
    tick();
    load_en  = 1'b0;
  endtask

  task automatic start_move(input int t, input int s);
    logic d0;
    d0           = e_dir(cyc - m_go_cyc);
    m_dir0       = d0;
    m_rst        = 1'b0;
    m_valid      = 1'b1;
    m_p0         = int'($signed(pos));
    m_t          = t;
    m_per        = (s < 2) ? 2 : s;
    m_go_cyc     = cyc;
    m_end        = 1 << 30;
    obs_steps.delete();
    obs_done     = -1;
    obs_dir0_cnt = 0;
    obs_busy_cnt = 0;
    obs_dir_c1   = -1;
    target       = PW'(t);
    sp           = QW'(s);
    go           = 1'b1;
    tick();
    go           = 1'b0;
  endtask

  task automatic do_stop();
    int rel;
    rel = cyc - m_go_cyc;
    if (m_end > rel) m_end = rel;
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic do_reset();
    int rel;
    rel     = cyc - m_go_cyc;
    if (m_end > rel) m_end = rel;
    m_rst   = 1'b1;
    m_rst_c = rel;
    rst_n   = 1'b0;
    tick();
    rst_n   = 1'b1;
  endtask

  task automatic chk_steps(input string tag, input int exp[$]);
    chk({tag, "_nsteps"}, obs_steps.size(), exp.size());
    for (int k = 0; k < exp.size(); k++)
      chk($sformatf("%s_step%0d", tag, k), (k < obs_steps.size()) ? obs_steps[k] : -1, exp[k]);
  endtask

  initial begin
    rst_n    = 1'b0;
    go       = 1'b0;
    stop     = 1'b0;
    target   = '0;
    sp       = '0;
    load_en  = 1'b1;
    load_val = '0;
    chk_en   = 1'b0;
    cyc      = 0;
    n_cmp    = 0;
    n_err    = 0;
    m_valid  = 1'b0;
    m_dir0   = 1'b1;
    m_rst    = 1'b0;
    m_rst_c  = 0;
    m_go_cyc = 0;
    m_end    = 0;
    m_p0     = 0;
    m_t      = 0;
    m_per    = 2;
    obs_done = -1;
    obs_dir0_cnt = 0;
    obs_busy_cnt = 0;
    obs_dir_c1   = -1;
    tick();
    tick();
    load_en = 1'b0;
    rst_n   = 1'b1;
    chk_en  = 1'b1;
    tick();

    // 1: 0 -> 3, period 5; a go while busy must be ignored.
    start_move(3, 5);
    run(2);
    go = 1'b1; target = PW'(-5); sp = QW'(9);
    tick();
    go = 1'b0;
    run(14);
    chk_steps("t1", '{1, 6, 11});
    chk("t1_done", obs_done, 16);
    chk("t1_pos", int'($signed(pos)), 3);
    chk("t1_dir_low_cycles", obs_dir0_cnt, 0);

    // 2: 3 -> 1, period 3, direction reversal with setup time.
    start_move(1, 3);
    run(12);
    chk("t2_dir_c1", obs_dir_c1, 0);
    chk_steps("t2", '{5, 8});
    chk("t2_done", obs_done, 11);
    chk("t2_pos", int'($signed(pos)), 1);

    // 3: already at target.
    load(7);
    start_move(7, 9);
    run(4);
    chk("t3_done", obs_done, 1);
    chk("t3_nsteps", obs_steps.size(), 0);
    chk("t3_busy_cycles", obs_busy_cnt, 0);

    // stop and go together: go ignored.
    go = 1'b1; stop = 1'b1; target = PW'(20); sp = QW'(3);
    tick();
    go = 1'b0; stop = 1'b0;
    run(3);
    chk("stopgo_pos", int'($signed(pos)), 7);

    // 4: period 0 and period 1 both clamp to 2.
    do_reset();
    load(0);
    start_move(4, 0);
    run(10);
    chk_steps("t4a", '{1, 3, 5, 7});
    chk("t4a_done", obs_done, 9);
    load(0);
    start_move(4, 1);
    run(10);
    chk_steps("t4b", '{1, 3, 5, 7});
    chk("t4b_done", obs_done, 9);
    chk("t4b_pos", int'($signed(pos)), 4);

    // 5: stop in cycle 6 of a 0 -> 10 move.
    load(0);
    start_move(10, 4);
    run(5);
    do_stop();
    run(4);
    chk_steps("t5", '{1, 5});
    chk("t5_busy_cycles", obs_busy_cnt, 6);
    chk("t5_done", obs_done, -1);
    chk("t5_pos", int'($signed(pos)), 2);

    // 5b: reset in cycle 6 of the same move.
    load(0);
    start_move(10, 4);
    run(5);
    do_reset();
    run(4);
    chk_steps("t5b", '{1, 5});
    chk("t5b_pos", int'($signed(pos)), 2);

    // 6: full range -512 -> 511 at period 2.
    load(-512);
    start_move(511, 2);
    run(2052);
    chk("t6_nsteps", obs_steps.size(), 1023);
    chk("t6_done", obs_done, 2047);
    chk("t6_dir_low_cycles", obs_dir0_cnt, 0);
    chk("t6_pos", int'($signed(pos)), 511);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
